obi_spi_xfer_scheduler: RTL

- OBI manager that shares the SPI transmit peripheral between NumReq byte-requesters.
- Round-robin arbitration picks one requester's byte. The block then sequences the register accesses (CLK_DIV if changed, DATA_TX, CTRL start) and polls STATUS until idle.
- Reports completion or error back to the winning requester.
- Sits in the user domain between client logic and the SPI peripheral's OBI subordinate port.

---
 rtl/spi_sched_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/obi_spi_xfer_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_sched_pkg.sv
// Shared definitions for the OBI SPI transfer scheduler: register map, CTRL bit layout, FSM states.
// Pure declarations, no timing or flow-control behaviour of its own.
package spi_sched_pkg;

  localparam logic [31:0] RegCtrl   = 32'h0000_0000;
  localparam logic [31:0] RegStatus = 32'h0000_0004;
  localparam logic [31:0] RegDataTx = 32'h0000_0008;
  localparam logic [31:0] RegClkDiv = 32'h0000_000C;

  localparam int unsigned CtrlEnable = 0;
  localparam int unsigned CtrlStart  = 1;
  localparam int unsigned CtrlCpol   = 2;
  localparam int unsigned CtrlCpha   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_POLL,
    ST_ABORT,
    ST_DONE
  } state_e;

  function automatic logic [31:0] ctrl_word(input logic en, input logic start,
                                            input logic cpol, input logic cpha);
    logic [31:0] w;
    w             = '0;
    w[CtrlEnable] = en;
    w[CtrlStart]  = start;
    w[CtrlCpol]   = cpol;
    w[CtrlCpha]   = cpha;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: zero-latency grant of the first request at or after the pointer (wrapping).
// The pointer moves past the winner only in cycles where update_i accepts the grant.
module rr_arbiter #(
  parameter int unsigned  NumReq = 2,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              update_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              vld_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
      if (!vld_o && req_i[cand[IdxW-1:0]]) begin
        vld_o = 1'b1;
        idx_o = cand[IdxW-1:0];
      end
    end
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

  assign ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + IdxW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (update_i && vld_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/obi_spi_xfer_scheduler.sv
// Shares the SPI TX peripheral between NumReq byte requesters over one OBI manager port.
// Accept is same-cycle from IDLE; one OBI access outstanding, request held until grant.
module obi_spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned PollTimeout = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq-1:0][7:0] req_data_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [NumReq-1:0]      done_o,
  output logic                   xfer_err_o,
  output logic                   busy_o,
  input  logic [7:0]             cfg_clk_div_i,
  input  logic                   cfg_cpol_i,
  input  logic                   cfg_cpha_i,
  output logic                   obi_req_o,
  output logic                   obi_we_o,
  output logic [3:0]             obi_be_o,
  output logic [31:0]            obi_addr_o,
  output logic [31:0]            obi_wdata_o,
  input  logic                   obi_gnt_i,
  input  logic                   obi_rvalid_i,
  input  logic [31:0]            obi_rdata_i,
  input  logic                   obi_err_i
);

  localparam int unsigned     IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned     CntW   = $clog2(PollTimeout + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PollTimeout);

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [7:0]          byte_q;
  logic [7:0]          div_q;
  logic                cpol_q, cpha_q;
  logic [7:0]          shadow_q;
  logic                shadow_vld_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                obi_req_q;
  logic [NumReq-1:0]   done_q;
  logic                xerr_q;

  logic [NumReq-1:0]   arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_vld;
  logic                unused_rdata;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_valid_i),
    .update_i (state_q == ST_IDLE),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx),
    .vld_o    (arb_vld)
  );

  assign cnt_d        = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign unused_rdata = ^obi_rdata_i[31:1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      byte_q       <= '0;
      div_q        <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      cnt_q        <= '0;
      obi_req_q    <= 1'b0;
      done_q       <= '0;
      xerr_q       <= 1'b0;
    end else begin
      done_q <= '0;
      xerr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            idx_q     <= arb_idx;
            byte_q    <= req_data_i[arb_idx];
            div_q     <= cfg_clk_div_i;
            cpol_q    <= cfg_cpol_i;
            cpha_q    <= cfg_cpha_i;
            obi_req_q <= 1'b1;
            state_q   <= (!shadow_vld_q || (cfg_clk_div_i != shadow_q)) ? ST_CFG : ST_WR_DATA;
          end
        end
        ST_CFG, ST_WR_DATA, ST_WR_CTRL, ST_POLL, ST_ABORT: begin
          // obi_req_q doubles as the REQ/WAIT phase of the current access
          if (obi_req_q) begin
            if (obi_gnt_i) obi_req_q <= 1'b0;
          end else if (obi_rvalid_i) begin
            if (obi_err_i || (state_q == ST_ABORT)) begin
              state_q       <= ST_DONE;
              done_q[idx_q] <= 1'b1;
              xerr_q        <= 1'b1;
            end else begin
              unique case (state_q)
                ST_CFG: begin
                  shadow_q     <= div_q;
                  shadow_vld_q <= 1'b1;
                  obi_req_q    <= 1'b1;
                  state_q      <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                  obi_req_q <= 1'b1;
                  state_q   <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                  cnt_q     <= '0;
                  obi_req_q <= 1'b1;
                  state_q   <= ST_POLL;
                end
                ST_POLL: begin
                  if (!obi_rdata_i[0]) begin
                    state_q       <= ST_DONE;
                    done_q[idx_q] <= 1'b1;
                  end else begin
                    cnt_q     <= cnt_d;
                    obi_req_q <= 1'b1;
                    if (cnt_d == CntMax) state_q <= ST_ABORT;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Access fields are a pure decode of the latched state, so they stay stable until grant.
  always_comb begin
    obi_we_o    = 1'b0;
    obi_addr_o  = '0;
    obi_wdata_o = '0;
    unique case (state_q)
      ST_CFG: begin
        obi_we_o    = 1'b1;
        obi_addr_o  = BaseAddr + RegClkDiv;
        obi_wdata_o = {24'h0, div_q};
      end
      ST_WR_DATA: begin
        obi_we_o    = 1'b1;
        obi_addr_o  = BaseAddr + RegDataTx;
        obi_wdata_o = {24'h0, byte_q};
      end
      ST_WR_CTRL: begin
        obi_we_o    = 1'b1;
        obi_addr_o  = BaseAddr + RegCtrl;
        obi_wdata_o = ctrl_word(1'b1, 1'b1, cpol_q, cpha_q);
      end
      ST_POLL: begin
        obi_addr_o  = BaseAddr + RegStatus;
      end
      ST_ABORT: begin
        obi_we_o    = 1'b1;
        obi_addr_o  = BaseAddr + RegCtrl;
        obi_wdata_o = ctrl_word(1'b0, 1'b0, 1'b0, 1'b0);
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign done_o      = done_q;
  assign xfer_err_o  = xerr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign obi_req_o   = obi_req_q;
  assign obi_be_o    = 4'hF;

endmodule
